// File: rtl/seven_segment_capture_if.sv
// Capture-side bundle: multiplexed segment bus in, decoded digits out.
// Master drives sel/seg/clr; slave is the capture block.
interface seven_segment_capture_if #(
   parameter int NDIG = 4
);
   logic [NDIG-1:0]   sel;
   logic [7:0]        seg;
   logic              clr;
   logic [4*NDIG-1:0] digits;
   logic [NDIG-1:0]   valid;
   logic [NDIG-1:0]   dp;
   logic              upd;
   logic              err;

   modport master (
      output sel, seg, clr,
      input  digits, valid, dp, upd, err
   );

   modport slave (
      input  sel, seg, clr,
      output digits, valid, dp, upd, err
   );
endinterface

// File: rtl/seven_segment_capture.sv
// Debounced seven-segment bus capture and hex decode per digit.
// Optional sticky error flag enabled by `define SEG_CAPTURE_ERR_EN.
module seven_segment_capture #(
   parameter int NDIG   = 4,
   parameter int STABLE = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   seven_segment_capture_if.slave bus
);
   localparam int         W   = NDIG + 8;
   localparam logic [7:0] STB = 8'(STABLE);

   logic [W-1:0]      r_q, r_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [4*NDIG-1:0] digits_q, digits_d;
   logic [NDIG-1:0]   valid_q, valid_d;
   logic [NDIG-1:0]   dp_q, dp_d;
   logic              upd_q, upd_d;

   logic            same, commit, one_hot, hit;
   logic [NDIG-1:0] sel_n;
   logic [7:0]      sseg;
   logic [3:0]      code;

   assign same    = ({bus.sel, bus.seg} == r_q);
   assign commit  = same && (cnt_q == STB - 8'd1);
   assign sel_n   = ~r_q[W-1:8];
   assign sseg    = r_q[7:0];
   assign one_hot = ($countones(sel_n) == 1);

   always_comb begin
      r_d   = r_q;
      cnt_d = 8'd1;
      if (same) begin
         cnt_d = (cnt_q >= STB) ? STB : cnt_q + 8'd1;
      end else begin
         r_d = {bus.sel, bus.seg};
      end
   end

   // dp is masked off so the table matches the encoder's dp=0 bytes
   always_comb begin
      hit  = 1'b1;
      code = 4'h0;
      unique case ({sseg[7:1], 1'b0})
         8'hFC: code = 4'h0;
         8'h60: code = 4'h1;
         8'hDA: code = 4'h2;
         8'hF2: code = 4'h3;
         8'h66: code = 4'h4;
         8'hB6: code = 4'h5;
         8'hBE: code = 4'h6;
         8'hE0: code = 4'h7;
         8'hFE: code = 4'h8;
         8'hF6: code = 4'h9;
         8'hEE: code = 4'hA;
         8'h3E: code = 4'hB;
         8'h1A: code = 4'hC;
         8'h7A: code = 4'hD;
         8'h9E: code = 4'hE;
         8'h8E: code = 4'hF;
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      dp_d     = dp_q;
      upd_d    = 1'b0;
      if (commit && one_hot) begin
         upd_d = 1'b1;
         for (int i = 0; i < NDIG; i++) begin
            if (sel_n[i]) begin
               if (hit) begin
                  digits_d[4*i +: 4] = code;
                  dp_d[i]            = sseg[0];
                  valid_d[i]         = 1'b1;
               end else begin
                  valid_d[i] = 1'b0;
               end
            end
         end
      end
      if (bus.clr) valid_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q      <= '1;
         cnt_q    <= '0;
         digits_q <= '0;
         valid_q  <= '0;
         dp_q     <= '0;
         upd_q    <= 1'b0;
      end else begin
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         dp_q     <= dp_d;
         upd_q    <= upd_d;
      end
   end

   assign bus.digits = digits_q;
   assign bus.valid  = valid_q;
   assign bus.dp     = dp_q;
   assign bus.upd    = upd_q;

`ifdef SEG_CAPTURE_ERR_EN
   logic err_q, err_d;
   logic multi;

   assign multi = ($countones(sel_n) > 1);

   always_comb begin
      err_d = err_q;
      if (commit && ((one_hot && !hit) || multi)) err_d = 1'b1;
      if (bus.clr) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (NDIG=4, STABLE=4).
// Expected values are hand-derived from the segment map.
module tb_seven_segment_capture;
   localparam int NDIG   = 4;
   localparam int STABLE = 4;
`ifdef SEG_CAPTURE_ERR_EN
   localparam logic EE = 1'b1;
`else
   localparam logic EE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   upd_n;

   seven_segment_capture_if #(.NDIG(NDIG)) bus ();

   seven_segment_capture #(
      .NDIG  (NDIG),
      .STABLE(STABLE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // entered and left at a negedge; counts upd once per cycle
   task automatic drive(input logic [3:0] s, input logic [7:0] g,
                        input int n);
      bus.sel = s;
      bus.seg = g;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.upd === 1'b1) upd_n++;
      end
      @(negedge clk);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      upd_n   = 0;
      rst_n   = 1'b0;
      bus.sel = 4'hF;
      bus.seg = 8'h00;
      bus.clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_digits", 32'(bus.digits), 32'h0);
      chk("rst_valid", 32'(bus.valid), 32'h0);
      chk("rst_dp", 32'(bus.dp), 32'h0);
      chk("rst_upd", 32'(bus.upd), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      rst_n = 1'b1;

      drive(4'b1110, 8'hF2, 4);
      chk("d0_is3", 32'(bus.digits[3:0]), 32'h3);
      chk("d0_valid", 32'(bus.valid), 32'h1);
      chk("d0_upd1", 32'(upd_n), 32'd1);
      drive(4'b1110, 8'hF2, 4);
      chk("hold_noupd", 32'(upd_n), 32'd1);

      drive(4'b1110, 8'hB6, 4);
      drive(4'b1101, 8'h9E, 4);
      drive(4'b1011, 8'h3E, 4);
      drive(4'b0111, 8'h61, 4);
      chk("sweep_dig", 32'(bus.digits), 32'h1BE5);
      chk("sweep_dp", 32'(bus.dp), 32'h8);
      chk("sweep_valid", 32'(bus.valid), 32'hF);
      chk("sweep_upd", 32'(upd_n), 32'd5);

      drive(4'b1110, 8'hF2, 3);
      drive(4'b1110, 8'hF6, 4);
      chk("short_dig", 32'(bus.digits), 32'h1BE9);
      chk("short_upd", 32'(upd_n), 32'd6);

      drive(4'b1101, 8'h02, 4);
      chk("bad_valid", 32'(bus.valid), 32'hD);
      chk("bad_dig", 32'(bus.digits), 32'h1BE9);
      chk("bad_err", 32'(bus.err), 32'(EE));
      chk("bad_upd", 32'(upd_n), 32'd7);
      bus.clr = 1'b1;
      drive(4'b1101, 8'h02, 1);
      bus.clr = 1'b0;
      chk("clr_err", 32'(bus.err), 32'h0);
      chk("clr_valid", 32'(bus.valid), 32'h0);
      chk("clr_dig", 32'(bus.digits), 32'h1BE9);

      drive(4'b1100, 8'hF2, 4);
      chk("multi_upd", 32'(upd_n), 32'd7);
      chk("multi_dig", 32'(bus.digits), 32'h1BE9);
      chk("multi_err", 32'(bus.err), 32'(EE));
      drive(4'b1111, 8'hF2, 4);
      chk("blank_upd", 32'(upd_n), 32'd7);
      chk("blank_valid", 32'(bus.valid), 32'h0);

      drive(4'b1110, 8'hF6, 4);
      chk("pre_valid", 32'(bus.valid), 32'h1);
      chk("pre_upd", 32'(upd_n), 32'd8);
      drive(4'b1101, 8'h60, 2);
      rst_n = 1'b0;
      #1;
      chk("arst_dig", 32'(bus.digits), 32'h0);
      chk("arst_valid", 32'(bus.valid), 32'h0);
      chk("arst_err", 32'(bus.err), 32'h0);
      chk("arst_upd", 32'(bus.upd), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1101, 8'h60, 3);
      chk("post_nocommit", 32'(bus.valid), 32'h0);
      chk("post_noupd", 32'(upd_n), 32'd8);
      drive(4'b1101, 8'h60, 1);
      chk("post_dig", 32'(bus.digits), 32'h0010);
      chk("post_valid", 32'(bus.valid), 32'h2);
      chk("post_upd", 32'(upd_n), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
